// File: rtl/vga_pkg.sv
// Shared VGA timing constants and pixel types for the 640x480@60 output path.
package vga_pkg;

   localparam int unsigned COORD_W = 10;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;

   localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that aligns sync/blank flags with renderer latency.
module sync_delay #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sr_q [DEPTH];

   // Shift one stage per cycle; reset flushes every stage to inactive.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: counters, pixel requests, latency-matched sync/blank, pin drive.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT     = H_FRONT_DEF,
   parameter int unsigned H_SYNC      = H_SYNC_DEF,
   parameter int unsigned H_BACK      = H_BACK_DEF,
   parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT     = V_FRONT_DEF,
   parameter int unsigned V_SYNC      = V_SYNC_DEF,
   parameter int unsigned V_BACK      = V_BACK_DEF,
   parameter int unsigned PIX_LATENCY = 1
) (
   input  logic       CLK_25MHZ,
   input  logic       RESET,
   output coord_t     PIX_X,
   output coord_t     PIX_Y,
   output logic       PIX_VALID,
   input  logic [7:0] PIX_R,
   input  logic [7:0] PIX_G,
   input  logic [7:0] PIX_B,
   output logic       FRAME_START,
   output logic       FRAME_END,
   output logic       VGA_HSYNC,
   output logic       VGA_VSYNC,
   output logic [7:0] VGA_RED,
   output logic [7:0] VGA_GREEN,
   output logic [7:0] VGA_BLUE
);

   localparam int unsigned LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START    = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END      = HS_START + H_SYNC;
   localparam int unsigned VS_START    = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END      = VS_START + V_SYNC;

   // Reject timing that does not fit the 10-bit counters or an unsupported latency.
   if (LINE_LEN > 1024 || FRAME_LINES > 1024 || PIX_LATENCY < 1 || PIX_LATENCY > 4) begin : g_bad_cfg
      $fatal(1, "vga_timing_ctrl: invalid timing parameters");
   end

   coord_t hcnt_q, hcnt_d;
   coord_t vcnt_q, vcnt_d;

   coord_t pix_x_q, pix_y_q;
   logic   pix_valid_q, hs1_q, vs1_q, fs_q, fe_q;

   logic   hs_dly, vs_dly, de_dly;
   logic   hsync_q, vsync_q;
   rgb_t   rgb_q;

   // Next raster position: wrap the line, and the frame on the last line.
   always_comb begin
      hcnt_d = hcnt_q + COORD_W'(1);
      vcnt_d = vcnt_q;
      if (hcnt_q == COORD_W'(LINE_LEN - 1)) begin
         hcnt_d = '0;
         if (vcnt_q == COORD_W'(FRAME_LINES - 1)) vcnt_d = '0;
         else                                     vcnt_d = vcnt_q + COORD_W'(1);
      end
   end

   // Raster counters.
   always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   // Stage 1: pixel request plus raw sync/blank flags and frame strobes.
   always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_valid_q <= 1'b0;
         hs1_q       <= 1'b0;
         vs1_q       <= 1'b0;
         fs_q        <= 1'b0;
         fe_q        <= 1'b0;
      end else begin
         pix_x_q     <= hcnt_q;
         pix_y_q     <= vcnt_q;
         pix_valid_q <= (hcnt_q < COORD_W'(H_VISIBLE)) && (vcnt_q < COORD_W'(V_VISIBLE));
         hs1_q       <= (hcnt_q >= COORD_W'(HS_START)) && (hcnt_q < COORD_W'(HS_END));
         vs1_q       <= (vcnt_q >= COORD_W'(VS_START)) && (vcnt_q < COORD_W'(VS_END));
         fs_q        <= (hcnt_q == '0) && (vcnt_q == '0);
         fe_q        <= (hcnt_q == '0) && (vcnt_q == COORD_W'(V_VISIBLE));
      end
   end

   sync_delay #(
      .DEPTH (PIX_LATENCY),
      .WIDTH (3)
   ) u_sync_delay (
      .clk_i (CLK_25MHZ),
      .rst_i (RESET),
      .d_i   ({hs1_q, vs1_q, pix_valid_q}),
      .q_o   ({hs_dly, vs_dly, de_dly})
   );

   // Pin stage: active-low sync and blank-gated colour.
   always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         rgb_q   <= '0;
      end else begin
         hsync_q <= ~hs_dly;
         vsync_q <= ~vs_dly;
         rgb_q   <= de_dly ? rgb_t'({PIX_R, PIX_G, PIX_B}) : '0;
      end
   end

   assign PIX_X       = pix_x_q;
   assign PIX_Y       = pix_y_q;
   assign PIX_VALID   = pix_valid_q;
   assign FRAME_START = fs_q;
   assign FRAME_END   = fe_q;
   assign VGA_HSYNC   = hsync_q;
   assign VGA_VSYNC   = vsync_q;
   assign VGA_RED     = rgb_q.r;
   assign VGA_GREEN   = rgb_q.g;
   assign VGA_BLUE    = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-size timing instance plus reduced-raster instances (latency 1..4).
module tb_vga_timing_ctrl;

   localparam longint unsigned SHV = 16, SHF = 4, SHS = 6, SHB = 4;
   localparam longint unsigned SVV = 8,  SVF = 2, SVS = 2, SVB = 3;
   localparam longint unsigned SHT = SHV + SHF + SHS + SHB;
   localparam longint unsigned SVT = SVV + SVF + SVS + SVB;
   localparam longint unsigned SFT = SHT * SVT;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       v;
      logic       fs;
      logic       fe;
      logic       hs;
      logic       vs;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } obs_t;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Expected outputs from edges elapsed since reset release, via linear pixel index.
   function automatic obs_t model(input longint unsigned since, input longint unsigned lat,
                                  input longint unsigned hv, input longint unsigned hf,
                                  input longint unsigned hsw, input longint unsigned hb,
                                  input longint unsigned vv, input longint unsigned vf,
                                  input longint unsigned vsw, input longint unsigned vb);
      obs_t o;
      longint unsigned ht, vt, ft, p, x, y;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      ft = ht * vt;
      o = '0;
      o.hs = 1'b1;
      o.vs = 1'b1;
      if (since >= 64'd1) begin
         p = (since - 64'd1) % ft;
         x = p % ht;
         y = p / ht;
         o.x  = 10'(x);
         o.y  = 10'(y);
         o.v  = (x < hv) && (y < vv);
         o.fs = (p == 64'd0);
         o.fe = (p == vv * ht);
      end
      if (since >= lat + 64'd2) begin
         p = (since - lat - 64'd2) % ft;
         x = p % ht;
         y = p / ht;
         o.hs = !((x >= hv + hf) && (x < hv + hf + hsw));
         o.vs = !((y >= vv + vf) && (y < vv + vf + vsw));
         if ((x < hv) && (y < vv)) begin
            o.r = 8'(x);
            o.g = 8'(y);
            o.b = 8'hAA;
         end
      end
      return o;
   endfunction

   task automatic check(input string name, input int idx, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] got x=%0d y=%0d v=%b fs=%b fe=%b hs=%b vs=%b rgb=%h expected x=%0d y=%0d v=%b fs=%b fe=%b hs=%b vs=%b rgb=%h",
                  name, idx, act.x, act.y, act.v, act.fs, act.fe, act.hs, act.vs, {act.r, act.g, act.b},
                  exp.x, exp.y, exp.v, exp.fs, exp.fe, exp.hs, exp.vs, {exp.r, exp.g, exp.b});
      end
   endtask

   task automatic check_int(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- full-size instance, latency 1 ----------------
   logic            rst_d;
   logic [9:0]      px_d, py_d;
   logic            pv_d, fs_d, fe_d, hs_d, vs_d;
   logic [7:0]      ri_d, gi_d, bi_d, ro_d, go_d, bo_d;
   logic [23:0]     ren_d;
   longint unsigned since_d = 0;
   logic            chk_d = 1'b0;

   vga_timing_ctrl u_dut (
      .CLK_25MHZ   (clk),
      .RESET       (rst_d),
      .PIX_X       (px_d),
      .PIX_Y       (py_d),
      .PIX_VALID   (pv_d),
      .PIX_R       (ri_d),
      .PIX_G       (gi_d),
      .PIX_B       (bi_d),
      .FRAME_START (fs_d),
      .FRAME_END   (fe_d),
      .VGA_HSYNC   (hs_d),
      .VGA_VSYNC   (vs_d),
      .VGA_RED     (ro_d),
      .VGA_GREEN   (go_d),
      .VGA_BLUE    (bo_d)
   );

   // Renderer: one-cycle latency, white outside the visible area.
   always @(posedge clk) ren_d <= pv_d ? {px_d[7:0], py_d[7:0], 8'hAA} : 24'hFFFFFF;
   assign {ri_d, gi_d, bi_d} = ren_d;

   always @(posedge clk) begin
      since_d <= rst_d ? 64'd0 : since_d + 64'd1;
      if (rst_d) chk_d <= 1'b1;
   end

   always @(negedge clk) begin
      if (chk_d)
         check("full", 0, {px_d, py_d, pv_d, fs_d, fe_d, hs_d, vs_d, ro_d, go_d, bo_d},
               model(since_d, 64'd1, 64'd640, 64'd16, 64'd96, 64'd48, 64'd480, 64'd10, 64'd2, 64'd33));
   end

   // ---------------- reduced-raster instances, latency 1..4 ----------------
   logic            rst_s;
   longint unsigned since_s = 0;
   logic            chk_s = 1'b0;

   always @(posedge clk) begin
      since_s <= rst_s ? 64'd0 : since_s + 64'd1;
      if (rst_s) chk_s <= 1'b1;
   end

   for (genvar g = 0; g < 4; g++) begin : g_small
      localparam int unsigned LAT = g + 1;
      logic [9:0]  px, py;
      logic        pv, fs, fe, hs, vs;
      logic [7:0]  ri, gi, bi, ro, go, bo;
      logic [23:0] pipe [4];

      vga_timing_ctrl #(
         .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
         .V_VISIBLE (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
         .PIX_LATENCY (LAT)
      ) u_dut (
         .CLK_25MHZ   (clk),
         .RESET       (rst_s),
         .PIX_X       (px),
         .PIX_Y       (py),
         .PIX_VALID   (pv),
         .PIX_R       (ri),
         .PIX_G       (gi),
         .PIX_B       (bi),
         .FRAME_START (fs),
         .FRAME_END   (fe),
         .VGA_HSYNC   (hs),
         .VGA_VSYNC   (vs),
         .VGA_RED     (ro),
         .VGA_GREEN   (go),
         .VGA_BLUE    (bo)
      );

      // Renderer: LAT-deep pipeline, random garbage outside the visible area.
      always @(posedge clk) begin
         pipe[0] <= pv ? {px[7:0], py[7:0], 8'hAA} : 24'($urandom);
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign {ri, gi, bi} = pipe[LAT-1];

      always @(negedge clk) begin
         if (chk_s)
            check("small", g, {px, py, pv, fs, fe, hs, vs, ro, go, bo},
                  model(since_s, 64'(LAT), SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB));
      end
   end

   // ---------------- directed table on the full-size instance ----------------
   typedef struct {
      longint unsigned e;
      logic [9:0]      x;
      logic [9:0]      y;
      logic            v;
      logic            fs;
      logic            hs;
      logic [23:0]     rgb;
   } vec_t;

   task automatic run_default();
      vec_t tbl [14];
      tbl[0]  = '{e: 1,    x: 0,   y: 0, v: 1, fs: 1, hs: 1, rgb: 24'h000000};
      tbl[1]  = '{e: 2,    x: 1,   y: 0, v: 1, fs: 0, hs: 1, rgb: 24'h000000};
      tbl[2]  = '{e: 3,    x: 2,   y: 0, v: 1, fs: 0, hs: 1, rgb: 24'h0000AA};
      tbl[3]  = '{e: 4,    x: 3,   y: 0, v: 1, fs: 0, hs: 1, rgb: 24'h0100AA};
      tbl[4]  = '{e: 640,  x: 639, y: 0, v: 1, fs: 0, hs: 1, rgb: 24'h7D00AA};
      tbl[5]  = '{e: 642,  x: 641, y: 0, v: 0, fs: 0, hs: 1, rgb: 24'h7F00AA};
      tbl[6]  = '{e: 643,  x: 642, y: 0, v: 0, fs: 0, hs: 1, rgb: 24'h000000};
      tbl[7]  = '{e: 658,  x: 657, y: 0, v: 0, fs: 0, hs: 1, rgb: 24'h000000};
      tbl[8]  = '{e: 659,  x: 658, y: 0, v: 0, fs: 0, hs: 0, rgb: 24'h000000};
      tbl[9]  = '{e: 754,  x: 753, y: 0, v: 0, fs: 0, hs: 0, rgb: 24'h000000};
      tbl[10] = '{e: 755,  x: 754, y: 0, v: 0, fs: 0, hs: 1, rgb: 24'h000000};
      tbl[11] = '{e: 801,  x: 0,   y: 1, v: 1, fs: 0, hs: 1, rgb: 24'h000000};
      tbl[12] = '{e: 803,  x: 2,   y: 1, v: 1, fs: 0, hs: 1, rgb: 24'h0001AA};
      tbl[13] = '{e: 1459, x: 658, y: 1, v: 0, fs: 0, hs: 0, rgb: 24'h000000};

      rst_d = 1'b1;
      repeat (5) @(negedge clk);
      rst_d = 1'b0;
      foreach (tbl[i]) begin
         while (since_d < tbl[i].e) @(negedge clk);
         n_cmp++;
         if ({px_d, py_d, pv_d, fs_d, hs_d, ro_d, go_d, bo_d} !==
             {tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].fs, tbl[i].hs, tbl[i].rgb}) begin
            n_bad++;
            $display("FAIL table[%0d] e=%0d got x=%0d y=%0d v=%b fs=%b hs=%b rgb=%h expected x=%0d y=%0d v=%b fs=%b hs=%b rgb=%h",
                     i, tbl[i].e, px_d, py_d, pv_d, fs_d, hs_d, {ro_d, go_d, bo_d},
                     tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].fs, tbl[i].hs, tbl[i].rgb);
         end
      end
      while (since_d < 64'd2500) @(negedge clk);
   endtask

   // ---------------- reduced-raster sequences: frame measurements and resets ----------------
   task automatic run_small();
      longint fs_t [$];
      longint fe_first;
      longint vlow;
      int     waited;
      fe_first = -1;
      vlow     = 0;

      rst_s = 1'b1;
      repeat (5) @(negedge clk);
      rst_s = 1'b0;
      for (longint i = 1; i <= longint'(2 * SFT + 20); i++) begin
         @(negedge clk);
         if (fs_t.size() == 1 && !g_small[0].vs) vlow++;
         if (g_small[0].fs) fs_t.push_back(i);
         if (g_small[0].fe && fe_first < 0) fe_first = i;
      end
      if (fs_t.size() >= 2) begin
         check_int("frame_period", fs_t[1] - fs_t[0], longint'(SFT));
         check_int("start_to_end", fe_first - fs_t[0], longint'(SVV * SHT));
         check_int("first_start", fs_t[0], 1);
      end else begin
         check_int("frame_start_count", longint'(fs_t.size()), 2);
      end
      check_int("vsync_low", vlow, longint'(SVS * SHT));

      // Reset while the pins are mid horizontal sync.
      waited = 0;
      while (g_small[0].hs && waited < int'(SFT)) begin
         @(negedge clk);
         waited++;
      end
      check_int("hsync_seen_low", longint'(g_small[0].hs), 0);
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      @(negedge clk);
      check_int("fs_after_reset", longint'(g_small[0].fs), 1);

      // Random reset pulses at random raster positions.
      repeat (8) begin
         repeat ($urandom_range(700, 50)) @(negedge clk);
         rst_s = 1'b1;
         repeat ($urandom_range(3, 1)) @(negedge clk);
         rst_s = 1'b0;
      end
      repeat (600) @(negedge clk);
   endtask

   initial begin
      rst_d = 1'b1;
      rst_s = 1'b1;
      fork
         run_default();
         run_small();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
